flash_rd_responder: RTL and testbench

Serves byte-stream read requests from the init loader. It accepts one request pulse carrying a byte address and a byte length. It then runs a 4-byte-address SPI NOR read (command 0x13, SPI mode 0) and returns the bytes in order on a valid/last/data stream. It sits between the init loader's request mux and the board SPI flash pins, on the sys_clk domain.

---
 rtl/flash_pkg.sv | 38 +++
 rtl/flash_rd_responder_if.sv | 25 ++
 rtl/spi_bit_engine.sv | 111 +++++++++++
 rtl/flash_rd_responder.sv | 170 +++++++++++++++++
 tb/tb_flash_rd_responder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash read responder: SPI opcodes, FSM encoding,
// SPI address width and the helper that selects the byte shifted out next.
package flash_pkg;

  localparam logic [7:0] READ4  = 8'h13;
  localparam int         ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DESEL
  } fsm_state_e;

  // Byte placed on mosi for the given phase; address bytes go out MSB first.
  function automatic logic [7:0] tx_sel(input fsm_state_e      st,
                                        input logic [1:0]      idx,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [7:0]      cmd);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      ST_CMD:  b = cmd;
      ST_ADDR: begin
        case (idx)
          2'd0:    b = addr[31:24];
          2'd1:    b = addr[23:16];
          2'd2:    b = addr[15:8];
          default: b = addr[7:0];
        endcase
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flash_rd_responder_if.sv
// Request/stream bundle between the init loader and the flash read responder.
interface flash_rd_responder_if;

  logic        init_flash_rden;
  logic [23:0] init_flash_length;
  logic [24:0] init_flash_addr;
  logic        init_flash_valid;
  logic        init_flash_last;
  logic [7:0]  init_flash_data;
  logic        flash_busy;
  logic        flash_req_err;

  modport master (
    output init_flash_rden, init_flash_length, init_flash_addr,
    input  init_flash_valid, init_flash_last, init_flash_data,
    input  flash_busy, flash_req_err
  );

  modport slave (
    input  init_flash_rden, init_flash_length, init_flash_addr,
    output init_flash_valid, init_flash_last, init_flash_data,
    output flash_busy, flash_req_err
  );

endinterface

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: divider, sck generation, 8-bit shift out/in.
// byte_done pulses the cycle after the 8th bit is sampled; byte_end marks the closing edge of a byte.
module spi_bit_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       active,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       byte_end
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       phase_q, phase_d;   // 0: low half of the bit, 1: high half
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic       tick;

  assign tick     = (div_q == DIV_LAST);
  assign byte_end = active && phase_q && tick && (bit_q == 3'd7);

  // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    if (start) begin
      div_d   = 8'd0;
      phase_d = 1'b0;
      bit_d   = 3'd0;
      sck_d   = 1'b0;
      mosi_d  = tx_byte[7];
      tx_sh_d = {tx_byte[6:0], 1'b0};
    end else if (!active) begin
      div_d   = 8'd0;
      phase_d = 1'b0;
      bit_d   = 3'd0;
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
    end else if (!tick) begin
      div_d = div_q + 8'd1;
    end else begin
      div_d = 8'd0;
      if (!phase_q) begin
        // Rising edge: miso was driven by the flash on the previous falling edge.
        phase_d = 1'b1;
        sck_d   = 1'b1;
        rx_sh_d = {rx_sh_q[6:0], miso};
        done_d  = (bit_q == 3'd7);
      end else begin
        phase_d = 1'b0;
        sck_d   = 1'b0;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          mosi_d  = tx_byte[7];
          tx_sh_d = {tx_byte[6:0], 1'b0};
        end else begin
          mosi_d  = tx_sh_q[7];
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= 8'd0;
      phase_q <= 1'b0;
      bit_q   <= 3'd0;
      tx_sh_q <= 8'h00;
      rx_sh_q <= 8'h00;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign rx_byte   = rx_sh_q;
  assign byte_done = done_q;

endmodule

// File: rtl/flash_rd_responder.sv
// Serves init-loader byte-stream reads with a 4-byte-address SPI NOR read (0x13, mode 0).
// Holds the request FSM, the byte counters and the valid/last/data output stream.
module flash_rd_responder
  import flash_pkg::*;
#(
  parameter int         CLK_DIV  = 2,
  parameter logic [7:0] CMD_READ = READ4,
  parameter int         TCSH     = 4
) (
  input  logic                 sys_clk,
  input  logic                 glbl_rst_n,
  flash_rd_responder_if.slave  init,
  output logic                 spi_cs_n,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam logic [3:0] DESEL_LAST = 4'(TCSH - 1);

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       len_q, len_d;
  logic [23:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0]        desel_q, desel_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [7:0]        data_q, data_d;
  logic              req_err_q, req_err_d;

  logic              accept;
  logic [7:0]        tx_byte;
  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              byte_end;
  logic              eng_active;

  assign eng_active = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    desel_d    = desel_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    data_d     = data_q;
    req_err_d  = 1'b0;
    accept     = 1'b0;

    if (init.init_flash_rden) begin
      if ((state_q == ST_IDLE) && (init.init_flash_length != 24'd0)) accept = 1'b1;
      else req_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_CMD;
          addr_d     = {7'b0, init.init_flash_addr};
          len_d      = init.init_flash_length;
          byte_cnt_d = 24'd0;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_CMD: begin
        if (byte_done) begin
          state_d    = ST_ADDR;
          byte_cnt_d = 24'd0;
        end
      end
      ST_ADDR: begin
        if (byte_done) begin
          if (byte_cnt_q == 24'd3) begin
            state_d    = ST_DATA;
            byte_cnt_d = 24'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 24'd1;
          end
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          valid_d    = 1'b1;
          data_d     = rx_byte;
          last_d     = (byte_cnt_q == len_q - 24'd1);
          byte_cnt_d = byte_cnt_q + 24'd1;
        end
        // The final byte may be counted on this same edge when CLK_DIV is 1.
        if (byte_end && (byte_cnt_d == len_q)) begin
          state_d = ST_DESEL;
          cs_n_d  = 1'b1;
          desel_d = DESEL_LAST;
        end
      end
      ST_DESEL: begin
        if (desel_q == 4'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          desel_d = desel_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Evaluated on the next state so the engine loads the right byte even at CLK_DIV=1.
    tx_byte = tx_sel(state_d, byte_cnt_d[1:0], addr_d, CMD_READ);
  end

  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= 24'd0;
      byte_cnt_q <= 24'd0;
      desel_q    <= 4'd0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= 8'h00;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      desel_q    <= desel_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      req_err_q  <= req_err_d;
    end
  end

  spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk       (sys_clk),
    .rst_n     (glbl_rst_n),
    .start     (accept),
    .active    (eng_active),
    .tx_byte   (tx_byte),
    .miso      (spi_miso),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .rx_byte   (rx_byte),
    .byte_done (byte_done),
    .byte_end  (byte_end)
  );

  assign spi_cs_n              = cs_n_q;
  assign init.init_flash_valid = valid_q;
  assign init.init_flash_last  = last_q;
  assign init.init_flash_data  = data_q;
  assign init.flash_busy       = busy_q;
  assign init.flash_req_err    = req_err_q;

endmodule

// File: tb/tb_flash_rd_responder.sv
// Directed bench for flash_rd_responder: three instances (CLK_DIV 2, 1, 7), each with a
// small SPI NOR model and a stream monitor sampling on the falling clock edge.
module tb_flash_rd_responder;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_clr;
  always #5 clk = ~clk;

  logic        rden   [N];
  logic [23:0] len    [N];
  logic [24:0] addr   [N];
  logic        valid  [N];
  logic        last   [N];
  logic [7:0]  data   [N];
  logic        busy   [N];
  logic        req_err[N];
  logic        cs_n   [N];
  logic        sck    [N];
  logic        mosi   [N];
  logic        miso   [N];

  logic [7:0]  model_bytes[N][16];

  int          bit_cnt[N], cs_low[N], cs_fall[N], gap_cnt[N], last_gap[N];
  int          desel_busy[N], sck_idle_hi[N], run_len[N], data_mosi[N];
  int          hi_min[N], hi_max[N], lo_min[N], lo_max[N];
  int          rx_cnt[N], last_cnt[N], last_idx[N], err_cnt[N], busy_cyc[N];
  logic [39:0] hdr[N];
  logic [7:0]  rx_data[N][32];
  logic        prev_sck[N], prev_cs[N];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

    flash_rd_responder_if bus ();

    assign bus.init_flash_rden   = rden[g];
    assign bus.init_flash_length = len[g];
    assign bus.init_flash_addr   = addr[g];
    assign valid[g]   = bus.init_flash_valid;
    assign last[g]    = bus.init_flash_last;
    assign data[g]    = bus.init_flash_data;
    assign busy[g]    = bus.flash_busy;
    assign req_err[g] = bus.flash_req_err;

    flash_rd_responder #(.CLK_DIV(DIV), .CMD_READ(8'h13), .TCSH(4)) u_dut (
      .sys_clk    (clk),
      .glbl_rst_n (rst_n),
      .init       (bus),
      .spi_cs_n   (cs_n[g]),
      .spi_sck    (sck[g]),
      .spi_mosi   (mosi[g]),
      .spi_miso   (miso[g])
    );

    // Flash model plus monitor; miso changes after each falling sck, ahead of the next rise.
    always @(negedge clk) begin : mon
      int idx;
      if (mon_clr) begin
        bit_cnt[g] = 0; cs_low[g] = 0; cs_fall[g] = 0; gap_cnt[g] = 0; last_gap[g] = 0;
        desel_busy[g] = 0; sck_idle_hi[g] = 0; run_len[g] = 0; data_mosi[g] = 0;
        hi_min[g] = 1000; hi_max[g] = 0; lo_min[g] = 1000; lo_max[g] = 0;
        rx_cnt[g] = 0; last_cnt[g] = 0; last_idx[g] = -1; err_cnt[g] = 0; busy_cyc[g] = 0;
        hdr[g] = '0; miso[g] = 1'b0;
      end else begin
        if (valid[g]) begin
          if (rx_cnt[g] < 32) rx_data[g][rx_cnt[g]] = data[g];
          if (last[g]) begin last_cnt[g]++; last_idx[g] = rx_cnt[g]; end
          rx_cnt[g]++;
        end
        if (req_err[g]) err_cnt[g]++;
        if (busy[g]) busy_cyc[g]++;
        if (cs_n[g] && sck[g]) sck_idle_hi[g]++;
        if (!cs_n[g]) begin
          if (prev_cs[g]) begin
            cs_fall[g]++; cs_low[g] = 1; bit_cnt[g] = 0; run_len[g] = 1;
            last_gap[g] = gap_cnt[g];
          end else begin
            cs_low[g]++;
            if (sck[g] != prev_sck[g]) begin
              if (sck[g]) begin
                if (run_len[g] < lo_min[g]) lo_min[g] = run_len[g];
                if (run_len[g] > lo_max[g]) lo_max[g] = run_len[g];
                if (bit_cnt[g] < 40) hdr[g] = {hdr[g][38:0], mosi[g]};
                else if (mosi[g]) data_mosi[g]++;
                bit_cnt[g]++;
              end else begin
                if (run_len[g] < hi_min[g]) hi_min[g] = run_len[g];
                if (run_len[g] > hi_max[g]) hi_max[g] = run_len[g];
                if (bit_cnt[g] >= 40) begin
                  idx = bit_cnt[g] - 40;
                  miso[g] = model_bytes[g][(idx / 8) % 16][7 - (idx % 8)];
                end
              end
              run_len[g] = 1;
            end else begin
              run_len[g]++;
            end
          end
        end else begin
          if (!prev_cs[g]) gap_cnt[g] = 1;
          else gap_cnt[g]++;
          if (busy[g]) desel_busy[g]++;
        end
      end
      prev_sck[g] = sck[g];
      prev_cs[g]  = cs_n[g];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic send(input int k, input logic [24:0] a, input logic [23:0] l);
    @(negedge clk); rden[k] = 1'b1; addr[k] = a; len[k] = l;
    @(negedge clk); rden[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input string tag);
    for (int n = 0; n < 20000 && busy[k]; n++) @(negedge clk);
    check({tag, "_busy_timeout"}, busy[k], 1'b0);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_rx(input int k, input int want, input string tag);
    for (int n = 0; n < 5000 && rx_cnt[k] < want; n++) @(negedge clk);
    check({tag, "_rx_timeout"}, rx_cnt[k] >= want, 1'b1);
  endtask

  task automatic set_model(input int k, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    model_bytes[k][0] = b0; model_bytes[k][1] = b1; model_bytes[k][2] = b2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mon_clr = 1'b1;
    for (int k = 0; k < N; k++) begin
      rden[k] = 1'b0; len[k] = 24'd0; addr[k] = 25'd0;
      for (int i = 0; i < 16; i++) model_bytes[k][i] = 8'h00;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid",   valid[0],   1'b0);
    check("rst_last",    last[0],    1'b0);
    check("rst_data",    data[0],    8'h00);
    check("rst_busy",    busy[0],    1'b0);
    check("rst_req_err", req_err[0], 1'b0);
    check("rst_cs_n",    cs_n[0],    1'b1);
    check("rst_sck",     sck[0],     1'b0);
    check("rst_mosi",    mosi[0],    1'b0);
    rst_n = 1'b1;
    clear_mon();

    // Basic read, CLK_DIV=2
    set_model(0, 8'hA5, 8'h5A, 8'hFF);
    send(0, 25'h0001234, 24'd3);
    wait_idle(0, "t1");
    check("t1_hdr",        hdr[0],         40'h13_00_00_12_34);
    check("t1_rx_cnt",     rx_cnt[0],      3);
    check("t1_byte0",      rx_data[0][0],  8'hA5);
    check("t1_byte1",      rx_data[0][1],  8'h5A);
    check("t1_byte2",      rx_data[0][2],  8'hFF);
    check("t1_last_cnt",   last_cnt[0],    1);
    check("t1_last_idx",   last_idx[0],    2);
    check("t1_cs_low",     cs_low[0],      256);
    check("t1_desel_busy", desel_busy[0],  4);
    check("t1_data_mosi",  data_mosi[0],   0);
    check("t1_hi_min",     hi_min[0],      2);
    check("t1_hi_max",     hi_max[0],      2);
    check("t1_lo_min",     lo_min[0],      2);
    check("t1_lo_max",     lo_max[0],      2);
    check("t1_sck_idle",   sck_idle_hi[0], 0);
    check("t1_req_err",    err_cnt[0],     0);

    // Top address, single byte
    clear_mon();
    set_model(0, 8'h3C, 8'h00, 8'h00);
    send(0, 25'h1FFFFFF, 24'd1);
    wait_idle(0, "t2");
    check("t2_hdr",      hdr[0],        40'h13_01_FF_FF_FF);
    check("t2_rx_cnt",   rx_cnt[0],     1);
    check("t2_byte0",    rx_data[0][0], 8'h3C);
    check("t2_last_idx", last_idx[0],   0);
    check("t2_cs_low",   cs_low[0],     192);

    // Zero-length request in IDLE
    clear_mon();
    send(0, 25'h0000055, 24'd0);
    repeat (10) @(posedge clk);
    check("t3_req_err", err_cnt[0],  1);
    check("t3_cs_fall", cs_fall[0],  0);
    check("t3_busy",    busy_cyc[0], 0);

    // Request while busy in DATA
    clear_mon();
    set_model(0, 8'hA5, 8'h5A, 8'hFF);
    send(0, 25'h0001234, 24'd3);
    wait_rx(0, 1, "t4");
    send(0, 25'h0000000, 24'd5);
    wait_idle(0, "t4");
    check("t4_req_err",  err_cnt[0],    1);
    check("t4_rx_cnt",   rx_cnt[0],     3);
    check("t4_last_idx", last_idx[0],   2);
    check("t4_byte2",    rx_data[0][2], 8'hFF);
    check("t4_cs_fall",  cs_fall[0],    1);

    // Reset during the second data byte
    clear_mon();
    send(0, 25'h0001234, 24'd3);
    wait_rx(0, 1, "t5");
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_cs_n_async", cs_n[0],  1'b1);
    check("t5_sck_async",  sck[0],   1'b0);
    check("t5_busy_async", busy[0],  1'b0);
    repeat (5) @(posedge clk);
    check("t5_no_valid",   rx_cnt[0], 1);
    @(negedge clk); rst_n = 1'b1;
    clear_mon();
    send(0, 25'h0000100, 24'd2);
    wait_idle(0, "t5b");
    check("t5b_rx_cnt",   rx_cnt[0],     2);
    check("t5b_byte0",    rx_data[0][0], 8'hA5);
    check("t5b_byte1",    rx_data[0][1], 8'h5A);
    check("t5b_last_idx", last_idx[0],   1);

    // Back-to-back: second request in the first cycle busy is low
    clear_mon();
    set_model(0, 8'h3C, 8'h00, 8'h00);
    send(0, 25'h0000010, 24'd1);
    for (int n = 0; n < 2000 && busy[0]; n++) @(negedge clk);
    rden[0] = 1'b1; addr[0] = 25'h0000020; len[0] = 24'd1;
    @(negedge clk); rden[0] = 1'b0;
    wait_idle(0, "t6");
    check("t6_req_err",  err_cnt[0],  0);
    check("t6_cs_fall",  cs_fall[0],  2);
    check("t6_gap",      last_gap[0], 5);
    check("t6_rx_cnt",   rx_cnt[0],   2);
    check("t6_last_cnt", last_cnt[0], 2);

    // CLK_DIV=1 and CLK_DIV=7 sweep, 16 incrementing bytes
    clear_mon();
    for (int k = 1; k < N; k++)
      for (int i = 0; i < 16; i++) model_bytes[k][i] = 8'(i);
    send(1, 25'h0000100, 24'd16);
    send(2, 25'h0000100, 24'd16);
    wait_idle(2, "t7_div7");
    wait_idle(1, "t7_div1");
    for (int k = 1; k < N; k++) begin
      int dv;
      dv = (k == 1) ? 1 : 7;
      check($sformatf("t7_k%0d_rx_cnt", k),   rx_cnt[k],   16);
      check($sformatf("t7_k%0d_last_cnt", k), last_cnt[k], 1);
      check($sformatf("t7_k%0d_last_idx", k), last_idx[k], 15);
      check($sformatf("t7_k%0d_hi_min", k),   hi_min[k],   dv);
      check($sformatf("t7_k%0d_hi_max", k),   hi_max[k],   dv);
      check($sformatf("t7_k%0d_lo_min", k),   lo_min[k],   dv);
      check($sformatf("t7_k%0d_lo_max", k),   lo_max[k],   dv);
      check($sformatf("t7_k%0d_cs_low", k),   cs_low[k],   168 * 2 * dv);
      check($sformatf("t7_k%0d_hdr", k),      hdr[k],      40'h13_00_00_01_00);
      for (int i = 0; i < 16; i++)
        check($sformatf("t7_k%0d_byte%0d", k, i), rx_data[k][i], 8'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
